// File: rtl/device_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral register block.
// Ports: clk/rst, master 0/1 req/addr/wen/wdata/wstrb -> ready/rdata/err,
//        device port dev_addr/ren/wen/wdata/wstrb <- dev_rdata.
module device_bus_arbiter #(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter logic [31:0] WIN_MASK = 32'h0000_000F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] dev_addr,
  output logic        dev_ren,
  output logic        dev_wen,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_wstrb,
  input  logic [31:0] dev_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_cur;
  logic        r_wen;
  logic        r_hit;

  logic        w_any;
  logic        w_win;
  logic [31:0] w_addr;
  logic        w_wen;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_hit;
  logic [31:0] w_rd;

  // On a tie the master that did not win last time is granted.
  assign w_any   = m0_req | m1_req;
  assign w_win   = (m0_req & m1_req) ? ~r_last : m1_req;
  assign w_addr  = w_win ? m1_addr  : m0_addr;
  assign w_wen   = w_win ? m1_wen   : m0_wen;
  assign w_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_wstrb = w_win ? m1_wstrb : m0_wstrb;
  assign w_hit   = ((w_addr & ~WIN_MASK) == BASE);
  assign w_rd    = (r_hit & ~r_wen) ? dev_rdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_cur     <= 1'b0;
      r_wen     <= 1'b0;
      r_hit     <= 1'b0;
      dev_addr  <= 32'h0;
      dev_ren   <= 1'b0;
      dev_wen   <= 1'b0;
      dev_wdata <= 32'h0;
      dev_wstrb <= 4'h0;
      m0_ready  <= 1'b0;
      m0_rdata  <= 32'h0;
      m0_err    <= 1'b0;
      m1_ready  <= 1'b0;
      m1_rdata  <= 32'h0;
      m1_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cur     <= w_win;
            r_last    <= w_win;
            r_wen     <= w_wen;
            r_hit     <= w_hit;
            // Address is driven even on a miss; enables stay low.
            dev_addr  <= w_addr;
            dev_wdata <= w_wdata;
            dev_wstrb <= w_wstrb;
            dev_ren   <= w_hit & ~w_wen;
            dev_wen   <= w_hit & w_wen;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          dev_ren  <= 1'b0;
          dev_wen  <= 1'b0;
          m0_ready <= ~r_cur;
          m0_rdata <= r_cur ? 32'h0 : w_rd;
          m0_err   <= ~r_cur & ~r_hit;
          m1_ready <= r_cur;
          m1_rdata <= r_cur ? w_rd : 32'h0;
          m1_err   <= r_cur & ~r_hit;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          m0_ready <= 1'b0;
          m0_rdata <= 32'h0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_rdata <= 32'h0;
          m1_err   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_device_bus_arbiter.sv
// Testbench for device_bus_arbiter: table vectors, corner sequences,
// and random two-master traffic against a transaction-level model.
module tb_device_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m0_ready, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_req, m1_wen, m1_ready, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic        dev_ren, dev_wen;
  logic [3:0]  dev_wstrb;

  always #5 clk = ~clk;

  device_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dev_addr(dev_addr), .dev_ren(dev_ren), .dev_wen(dev_wen),
    .dev_wdata(dev_wdata), .dev_wstrb(dev_wstrb),
    .dev_rdata(dev_rdata)
  );

  // Register block stub: 0x0 LED, 0x4 switches (read-only), 0x8/0xC cfg.
  logic [31:0] dmem [4];
  logic [31:0] sw;
  assign dev_rdata = (dev_addr[3:2] == 2'd1) ? sw : dmem[dev_addr[3:2]];

  always @(posedge clk) begin
    if (dev_wen && dev_addr[3:2] != 2'd1)
      for (int b = 0; b < 4; b++)
        if (dev_wstrb[b])
          dmem[dev_addr[3:2]][8*b +: 8] <= dev_wdata[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        m;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] sw;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_ren;
    logic        e_wen;
  } vec_t;

  vec_t vt [12];

  task automatic run_vec(input int i, input vec_t v);
    int rdy_at = -1;
    int nren = 0;
    int nwen = 0;
    logic other = 1'b0;
    logic [31:0] rd = 32'h0;
    logic er = 1'b0;
    sw = v.sw;
    @(posedge clk); #1;
    if (v.m) begin
      m1_req = 1'b1; m1_addr = v.addr; m1_wen = v.wen;
      m1_wdata = v.wdata; m1_wstrb = v.wstrb;
    end else begin
      m0_req = 1'b1; m0_addr = v.addr; m0_wen = v.wen;
      m0_wdata = v.wdata; m0_wstrb = v.wstrb;
    end
    for (int k = 1; k <= 6 && rdy_at < 0; k++) begin
      @(negedge clk);
      nren += int'(dev_ren);
      nwen += int'(dev_wen);
      if (dev_wen && v.wen) begin
        chk($sformatf("v%0d_wstrb", i), 32'(dev_wstrb), 32'(v.wstrb));
        chk($sformatf("v%0d_wdata", i), dev_wdata, v.wdata);
      end
      if (v.m ? m0_ready : m1_ready) other = 1'b1;
      if (v.m ? m1_ready : m0_ready) begin
        rdy_at = k;
        rd = v.m ? m1_rdata : m0_rdata;
        er = v.m ? m1_err : m0_err;
      end
    end
    chk($sformatf("v%0d_latency", i), 32'(rdy_at), 32'd3);
    chk($sformatf("v%0d_rdata", i), rd, v.e_rdata);
    chk($sformatf("v%0d_err", i), 32'(er), 32'(v.e_err));
    chk($sformatf("v%0d_other_rdy", i), 32'(other), 32'd0);
    chk($sformatf("v%0d_nren", i), 32'(nren), 32'(v.e_ren));
    chk($sformatf("v%0d_nwen", i), 32'(nwen), 32'(v.e_wen));
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  // Transaction-level reference: a grant occupies three cycles, the
  // access is visible in the grant cycle, the response one cycle later.
  logic [31:0] mm [4];
  logic        md_last;
  int          md_free, md_acc, md_rdy;
  logic        md_who, md_ren, md_wen, md_err;
  logic [31:0] md_addr, md_wdata, md_rdat;
  logic [3:0]  md_wstrb;

  task automatic model_init();
    md_last = 1'b1; md_free = 0; md_acc = -10; md_rdy = -10;
    md_who = 1'b0; md_ren = 1'b0; md_wen = 1'b0; md_err = 1'b0;
    md_addr = 32'h0; md_wdata = 32'h0; md_rdat = 32'h0;
    md_wstrb = 4'h0;
  endtask

  task automatic model_step(input int c);
    logic w, we, hit;
    logic [1:0] idx;
    if (c >= md_free && (m0_req || m1_req)) begin
      w = (m0_req && m1_req) ? !md_last : m1_req;
      md_last = w;
      md_who = w;
      md_addr = w ? m1_addr : m0_addr;
      md_wdata = w ? m1_wdata : m0_wdata;
      md_wstrb = w ? m1_wstrb : m0_wstrb;
      we = w ? m1_wen : m0_wen;
      hit = (md_addr[31:4] == 28'h0);
      idx = md_addr[3:2];
      md_ren = hit && !we;
      md_wen = hit && we;
      md_err = !hit;
      md_rdat = 32'h0;
      if (md_ren) md_rdat = (idx == 2'd1) ? sw : mm[idx];
      if (md_wen && idx != 2'd1)
        for (int b = 0; b < 4; b++)
          if (md_wstrb[b]) mm[idx][8*b +: 8] = md_wdata[8*b +: 8];
      md_acc = c;
      md_rdy = c + 1;
      md_free = c + 3;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = $urandom | 32'h10;
    else a = {28'h0, 4'($urandom)};
    return a;
  endfunction

  int who [$];
  int at [$];

  initial begin
    logic seen, got, r0, r1, a, rq;
    int first, c;
    m0_addr = 0; m0_wen = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_addr = 0; m1_wen = 0; m1_wdata = 0; m1_wstrb = 0;
    sw = 32'h0;
    for (int i = 0; i < 4; i++) dmem[i] = 32'h0;
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    #2;
    chk("rst_flags",
        32'({m0_ready, m0_err, m1_ready, m1_err, dev_ren, dev_wen}),
        32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    chk("rst_dev", dev_addr | dev_wdata | 32'(dev_wstrb), 32'h0);
    do_reset();

    vt[0]  = '{1'b0, 32'h0, 1'b1, 32'hA5, 4'hF, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'hF, 32'h0,
               32'hA5, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 32'h4, 1'b0, 32'h0, 4'hF, 32'h1234,
               32'h1234, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 32'h100, 1'b0, 32'h0, 4'hF, 32'h1234,
               32'h0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 32'h8, 1'b1, 32'hDEADBEEF, 4'b0011, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 32'h8, 1'b0, 32'h0, 4'hF, 32'h0,
               32'h0000BEEF, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 32'h0, 1'b1, 32'h12345678, 4'b1100, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 32'h3, 1'b0, 32'h0, 4'hF, 32'h0,
               32'h123400A5, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 32'hC, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0,
               32'h0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 32'hC, 1'b0, 32'h0, 4'hF, 32'h0,
               32'h0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 32'h10, 1'b1, 32'h55, 4'hF, 32'h0,
               32'h0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 32'hFFFFFFF0, 1'b0, 32'h0, 4'hF, 32'h0,
               32'h0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);
    chk("led_reg", dmem[0], 32'h123400A5);

    // Fairness with both requests held continuously.
    do_reset();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h4;
    for (int k = 1; k <= 20 && who.size() < 4; k++) begin
      @(negedge clk);
      if (m0_ready && m1_ready) chk("fair_both_rdy", 32'd1, 32'd0);
      if (m0_ready) begin who.push_back(0); at.push_back(k); end
      if (m1_ready) begin who.push_back(1); at.push_back(k); end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    chk("fair_count", 32'(who.size()), 32'd4);
    for (int i = 0; i < who.size() && i < 4; i++) begin
      chk($sformatf("fair_who%0d", i), 32'(who[i]), 32'(i % 2));
      chk($sformatf("fair_at%0d", i), 32'(at[i]), 32'(3 + 3 * i));
    end

    // Reset during the access cycle of an m0 write.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 32'h8; m0_wen = 1'b1;
    m0_wdata = 32'hFFFFFFFF; m0_wstrb = 4'hF;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (dev_wen) seen = 1'b1;
    end
    chk("rstacc_seen", 32'(seen), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstacc_drop", 32'({dev_wen, dev_ren, m0_ready}), 32'd0);
    m0_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    got = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m0_ready) got = 1'b1;
    end
    chk("rstacc_no_rdy", 32'(got), 32'd0);
    chk("rstacc_no_wr", dmem[2], 32'h0000BEEF);
    @(posedge clk); #1;
    m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_wen = 1'b0; m1_addr = 32'h4;
    first = -1;
    for (int k = 0; k < 6 && first < 0; k++) begin
      @(negedge clk);
      if (m0_ready) first = 0;
      else if (m1_ready) first = 1;
    end
    chk("rstacc_first", 32'(first), 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;

    // Random traffic from both masters.
    do_reset();
    sw = $urandom;
    for (int i = 0; i < 4; i++) mm[i] = dmem[i];
    model_init();
    c = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      a = (c == md_acc);
      rq = (c == md_rdy);
      chk("r_dev_en", 32'({dev_ren, dev_wen}),
          32'({a & md_ren, a & md_wen}));
      chk("r_dev_addr", dev_addr, md_addr);
      chk("r_dev_wdata", dev_wdata, md_wdata);
      chk("r_dev_wstrb", 32'(dev_wstrb), 32'(md_wstrb));
      chk("r_m0_flags", 32'({m0_ready, m0_err}),
          32'({rq & !md_who, rq & !md_who & md_err}));
      chk("r_m0_rdata", m0_rdata, (rq && !md_who) ? md_rdat : 32'h0);
      chk("r_m1_flags", 32'({m1_ready, m1_err}),
          32'({rq & md_who, rq & md_who & md_err}));
      chk("r_m1_rdata", m1_rdata, (rq && md_who) ? md_rdat : 32'h0);
      r0 = m0_ready;
      r1 = m1_ready;
      @(posedge clk);
      c++;
      model_step(c);
      #1;
      if (r0) m0_req = 1'b0;
      if (r1) m1_req = 1'b0;
      if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1'b1; m0_addr = rnd_addr(); m0_wen = 1'($urandom);
        m0_wdata = $urandom; m0_wstrb = 4'($urandom);
      end
      if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1'b1; m1_addr = rnd_addr(); m1_wen = 1'($urandom);
        m1_wdata = $urandom; m1_wstrb = 4'($urandom);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("r_mem%0d", i), dmem[i], mm[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
